// File: rtl/mmaps_digitizer_pkg.sv
// Shared definitions for the PMT digitizer readout path: buffer geometry defaults,
// readout FSM states, header tag and ring buffer read latency.
package mmaps_digitizer_pkg;

  localparam int unsigned RB_SIZE_DEFAULT  = 12;
  localparam int unsigned RB_WIDTH_DEFAULT = 14;
  localparam int unsigned RB_RD_LAT        = 2;

  localparam logic [1:0] HDR_TAG = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHdr   = 2'd1,
    StRead  = 2'd2,
    StDrain = 2'd3
  } readout_state_e;

endpackage

// File: rtl/readout_skid_fifo.sv
// Small register-based FIFO holding readout words plus their last flag; exposes its
// occupancy so the caller can budget reads against free space.
module readout_skid_fifo #(
  parameter int unsigned Width = 15,
  parameter int unsigned Depth = 4,
  parameter int unsigned PtrW  = $clog2(Depth),
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             pop_eff;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // The caller never pushes into a full FIFO; credits guarantee space.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_eff  = pop_i && (count_q != '0);
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_eff) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CntW'(push_i) - CntW'(pop_eff);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/ringbuffer_readout.sv
// Trigger-driven window readout of the PMT sample ring buffer onto a valid/ready stream.
// Define RINGBUFFER_READOUT_HEADER_EN to prefix each window with a trigger-address header.
module ringbuffer_readout
  import mmaps_digitizer_pkg::*;
#(
  parameter int unsigned SIZE     = RB_SIZE_DEFAULT,
  parameter int unsigned WIDTH    = RB_WIDTH_DEFAULT,
  parameter int unsigned PRETRIG  = 64,
  parameter int unsigned POSTTRIG = 192
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic [SIZE-1:0]  wr_addr,
  output logic [SIZE-1:0]  ain,
  output logic             rd_en,
  input  logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      trig_lost
);

  localparam int unsigned Total     = PRETRIG + POSTTRIG;
  localparam int unsigned Lat       = RB_RD_LAT;
  localparam int unsigned KW        = SIZE + 1;
  localparam int unsigned FifoDepth = 4;

  readout_state_e   state_q, state_d;
  logic [SIZE-1:0]  trig_addr_q, trig_addr_d;
  logic [KW-1:0]    k_q, k_d;
  logic [SIZE-1:0]  ain_q, ain_d;
  logic [15:0]      trig_lost_q, trig_lost_d;
  // Stage 0: address presented, stage 1: rd_en, stage Lat: dout valid.
  logic [Lat:0]     pv_q, pv_d;
  logic [Lat:0]     pl_q, pl_d;

  logic [SIZE-1:0]  eff_trig;
  logic [SIZE-1:0]  written;
  logic [KW-1:0]    k_cur;
  logic [SIZE+1:0]  limit;
  logic             gate_ok;
  logic [3:0]       inflight;
  logic             credit_ok;
  logic             issue_window;
  logic             issue;
  logic             last_issue;
  logic             pop;
  logic             fifo_push;
  logic [WIDTH:0]   fifo_wdata;
  logic [WIDTH:0]   fifo_rdata;
  logic [2:0]       fifo_count;

`ifdef RINGBUFFER_READOUT_HEADER_EN
  localparam bit HeaderEn = 1'b1;
  logic [SIZE+1:0]  hdr_full;
  logic             hdr_push;
`else
  localparam bit HeaderEn = 1'b0;
`endif

  assign pop = out_valid && out_ready;

  always_comb begin
    eff_trig = (state_q == StIdle) ? wr_addr : trig_addr_q;
    written  = wr_addr - eff_trig;
    k_cur    = (state_q == StIdle) ? '0 : k_q;
    // Never read an address the writer has not reached yet.
    limit    = (SIZE + 2)'(PRETRIG) + (SIZE + 2)'(written);
    gate_ok  = ((SIZE + 2)'(k_cur) < limit);
    inflight = '0;
    for (int i = 0; i <= int'(Lat); i++) begin
      inflight = inflight + {3'b000, pv_q[i]};
    end
    // A word leaving this cycle frees its slot for a read issued now.
    credit_ok    = ((4'(fifo_count) + inflight) < (4'(FifoDepth) + 4'(pop)));
    issue_window = (state_q == StRead) || ((state_q == StIdle) && trigger && !HeaderEn);
    issue        = issue_window && (k_cur < KW'(Total)) && gate_ok && credit_ok;
    last_issue   = (k_cur == KW'(Total - 1));
  end

  always_comb begin
    state_d     = state_q;
    trig_addr_d = trig_addr_q;
    k_d         = k_q;
    ain_d       = ain_q;
    trig_lost_d = trig_lost_q;
    pv_d        = {pv_q[Lat-1:0], issue};
    pl_d        = {pl_q[Lat-1:0], issue && last_issue};
`ifdef RINGBUFFER_READOUT_HEADER_EN
    hdr_push    = 1'b0;
`endif

    if (issue) begin
      ain_d = eff_trig - SIZE'(PRETRIG) + k_cur[SIZE-1:0];
      k_d   = k_cur + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          trig_addr_d = wr_addr;
          if (!issue) begin
            k_d = '0;
          end
          state_d = HeaderEn ? StHdr : StRead;
        end
      end
`ifdef RINGBUFFER_READOUT_HEADER_EN
      StHdr: begin
        if (credit_ok) begin
          hdr_push = 1'b1;
          state_d  = StRead;
        end
      end
`endif
      StRead: begin
        state_d = StRead;
      end
      StDrain: begin
        if (pop && out_last) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (issue && last_issue) begin
      state_d = StDrain;
    end

    if (trigger && (state_q != StIdle) && (trig_lost_q != 16'hFFFF)) begin
      trig_lost_d = trig_lost_q + 16'd1;
    end
  end

`ifdef RINGBUFFER_READOUT_HEADER_EN
  assign hdr_full   = {HDR_TAG, trig_addr_q};
  assign fifo_push  = pv_q[Lat] || hdr_push;
  assign fifo_wdata = hdr_push ? {1'b0, WIDTH'(hdr_full)} : {pl_q[Lat], dout};
`else
  assign fifo_push  = pv_q[Lat];
  assign fifo_wdata = {pl_q[Lat], dout};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      trig_addr_q <= '0;
      k_q         <= '0;
      ain_q       <= '0;
      trig_lost_q <= '0;
      pv_q        <= '0;
      pl_q        <= '0;
    end else begin
      state_q     <= state_d;
      trig_addr_q <= trig_addr_d;
      k_q         <= k_d;
      ain_q       <= ain_d;
      trig_lost_q <= trig_lost_d;
      pv_q        <= pv_d;
      pl_q        <= pl_d;
    end
  end

  readout_skid_fifo #(
    .Width (WIDTH + 1),
    .Depth (FifoDepth)
  ) u_skid_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .valid_o (out_valid),
    .count_o (fifo_count)
  );

  assign ain       = ain_q;
  assign rd_en     = pv_q[1];
  assign out_data  = fifo_rdata[WIDTH-1:0];
  assign out_last  = fifo_rdata[WIDTH];
  assign busy      = (state_q != StIdle);
  assign trig_lost = trig_lost_q;

endmodule

// File: tb/tb_ringbuffer_readout.sv
// Directed bench for ringbuffer_readout with a 2-cycle-latency ring buffer model,
// an 8-sample window (PRETRIG=4, POSTTRIG=4) and immediate-assertion checks.
module tb_ringbuffer_readout;

  localparam int PRE = 4;
  localparam int POST = 4;
  localparam int TOT = PRE + POST;
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [11:0] ain;
  logic        rd_en;
  logic [13:0] dout = '0;
  logic [13:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic [15:0] trig_lost;

  int n_checks = 0;
  int n_err = 0;
  int wr_mode = 0;
  int rdy_mode = 0;
  int div = 0;

  logic [13:0] got_d[$];
  logic        got_l[$];
  logic [11:0] rd_addr_q[$];
  logic [11:0] rd_wr_q[$];

  logic [11:0] mem_addr_q = '0;
  logic [11:0] ain_d1 = '0;
  logic [11:0] wr_d1 = '0;
  logic [11:0] wr_d2 = '0;
  logic        stall_d1 = 1'b0;
  logic [13:0] data_d1 = '0;
  logic        last_d1 = 1'b0;
  int          stab_viol = 0;

  ringbuffer_readout #(
    .SIZE     (12),
    .WIDTH    (14),
    .PRETRIG  (PRE),
    .POSTTRIG (POST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trigger   (trigger),
    .wr_addr   (wr_addr),
    .ain       (ain),
    .rd_en     (rd_en),
    .dout      (dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .trig_lost (trig_lost)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] word_of(input logic [11:0] a);
    return {a[1:0], a} ^ 14'h2A5;
  endfunction

  // Ring buffer read port: address sampled, then data one rd_en cycle later.
  always @(posedge clk) begin
    mem_addr_q <= ain;
    if (rd_en) dout <= word_of(mem_addr_q);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      if (rd_en) begin
        rd_addr_q.push_back(ain_d1);
        rd_wr_q.push_back(wr_d2);
      end
      if (stall_d1 && !(out_valid && out_data === data_d1 && out_last === last_d1))
        stab_viol <= stab_viol + 1;
    end
    ain_d1   <= ain;
    wr_d1    <= wr_addr;
    wr_d2    <= wr_d1;
    stall_d1 <= rst_n && out_valid && !out_ready;
    data_d1  <= out_data;
    last_d1  <= out_last;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_mode == 1) begin
      wr_addr = wr_addr + 12'd1;
    end else if (wr_mode == 2) begin
      div++;
      if (div == 10) begin
        div = 0;
        wr_addr = wr_addr + 12'd1;
      end
    end
    if (rdy_mode == 1) out_ready = ($urandom_range(0, 99) < 30);
  endtask

  task automatic clear_logs();
    got_d.delete();
    got_l.delete();
    rd_addr_q.delete();
    rd_wr_q.delete();
  endtask

  task automatic trig_pulse(output logic [11:0] t);
    t = wr_addr;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n);
    int c = 0;
    while ((got_d.size() < n || busy) && c < BUDGET) begin
      tick();
      c++;
    end
    chk({tag, "_timeout"}, 32'(c < BUDGET), 32'd1);
    repeat (4) tick();
  endtask

  task automatic check_window(input string tag, input logic [11:0] trig);
    int n_hdr = 0;
    int bad = 0;
    logic [11:0] a;
    logic [11:0] wdiff;
`ifdef RINGBUFFER_READOUT_HEADER_EN
    n_hdr = 1;
    if (got_d.size() > 0) begin
      chk({tag, "_hdr"}, 32'(got_d[0]), 32'({2'b10, trig}));
      chk({tag, "_hdr_last"}, 32'(got_l[0]), 32'd0);
    end
`endif
    chk({tag, "_words"}, 32'(got_d.size()), 32'(TOT + n_hdr));
    chk({tag, "_reads"}, 32'(rd_addr_q.size()), 32'(TOT));
    for (int k = 0; k < TOT; k++) begin
      a = trig - 12'(PRE) + 12'(k);
      if (k < rd_addr_q.size())
        chk($sformatf("%s_ain%0d", tag, k), 32'(rd_addr_q[k]), 32'(a));
      if (k + n_hdr < got_d.size()) begin
        chk($sformatf("%s_data%0d", tag, k), 32'(got_d[k + n_hdr]), 32'(word_of(a)));
        chk($sformatf("%s_last%0d", tag, k), 32'(got_l[k + n_hdr]), 32'(k == TOT - 1));
      end
    end
    for (int k = 0; k < rd_wr_q.size(); k++) begin
      wdiff = rd_wr_q[k] - trig;
      if (!(k < PRE + int'(wdiff))) bad++;
    end
    chk({tag, "_gate"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [11:0] t;
    int c;

    // Reset state
    tick();
    chk("rst_ain", 32'(ain), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trig_lost", 32'(trig_lost), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: free-running writer at 1000, latency and sequence
    clear_logs();
    wr_addr = 12'd1000;
    wr_mode = 1;
    trig_pulse(t);
    chk("t1_busy_rise", 32'(busy), 32'd1);
`ifndef RINGBUFFER_READOUT_HEADER_EN
    chk("t1_first_ain", 32'(ain), 32'd996);
    chk("t1_rd_en_t", 32'(rd_en), 32'd0);
    tick();
    chk("t1_rd_en_t1", 32'(rd_en), 32'd1);
    chk("t1_second_ain", 32'(ain), 32'd997);
    tick();
    chk("t1_valid_t2", 32'(out_valid), 32'd0);
    tick();
    chk("t1_valid_t3", 32'(out_valid), 32'd1);
    chk("t1_data_t3", 32'(out_data), 32'(word_of(12'd996)));
`endif
    wait_done("t1", TOT);
    check_window("t1", t);

    // 2: address wrap below zero
    clear_logs();
    wr_addr = 12'd2;
    trig_pulse(t);
    wait_done("t2", TOT);
    check_window("t2", t);

    // 3: writer frozen at trigger, then creeping forward
    clear_logs();
    wr_mode = 0;
    wr_addr = 12'd500;
    trig_pulse(t);
    div = 0;
    wr_mode = 2;
    wait_done("t3", TOT);
    check_window("t3", t);

    // 4: random backpressure, 30% ready
    clear_logs();
    wr_mode = 1;
    wr_addr = 12'd3000;
    rdy_mode = 1;
    trig_pulse(t);
    wait_done("t4", TOT);
    rdy_mode = 0;
    out_ready = 1'b1;
    check_window("t4", t);
    chk("t4_stable", 32'(stab_viol), 32'd0);

    // 5: trigger while busy, then trigger right as busy falls
    clear_logs();
    wr_addr = 12'd2000;
    trig_pulse(t);
    repeat (3) tick();
    chk("t5_busy_mid", 32'(busy), 32'd1);
    trig_pulse(t);
    chk("t5_lost", 32'(trig_lost), 32'd1);
    c = 0;
    while (!(out_valid && out_ready && out_last) && c < 200) begin
      tick();
      c++;
    end
    chk("t5_last_seen", 32'(c < 200), 32'd1);
    tick();
    chk("t5_busy_fall", 32'(busy), 32'd0);
    clear_logs();
    trig_pulse(t);
    chk("t5_third_busy", 32'(busy), 32'd1);
    chk("t5_lost_hold", 32'(trig_lost), 32'd1);
    wait_done("t5", TOT);
    check_window("t5", t);

    // 6: asynchronous reset in the middle of a window
    clear_logs();
    wr_addr = 12'd100;
    trig_pulse(t);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ain", 32'(ain), 32'd0);
    chk("t6_rd_en", 32'(rd_en), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_data", 32'(out_data), 32'd0);
    chk("t6_last", 32'(out_last), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_trig_lost", 32'(trig_lost), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    trig_pulse(t);
    wait_done("t6", TOT);
    check_window("t6", t);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ringbuffer_readout.md
# ringbuffer_readout

Readout controller for the PMT sample ring buffer. On a trigger it captures the buffer's current write address, then reads a fixed window of samples around the trigger point: PRETRIG samples before it and POSTTRIG samples after it. It drives the buffer's read address and read enable, and presents the samples on a valid/ready stream toward the event builder / transmit path. It sits between the ring buffer's read port and the downstream packetiser, and is the consumer end of the buffer's write-address/read-data interface.

## Interface
- SIZE, 12: ring buffer address width; buffer depth is 2**SIZE.
- WIDTH, 14: sample width.
- PRETRIG, 64: samples read before the trigger address.
- POSTTRIG, 192: samples read from the trigger address onward. PRETRIG+POSTTRIG must be at most 2**SIZE-4.
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- trigger  in  1  single-cycle trigger pulse.
- wr_addr  in  SIZE  ring buffer write pointer, the next address to be written.
- ain  out  SIZE  ring buffer read address.
- rd_en  out  1  ring buffer read enable.
- dout  in  WIDTH  ring buffer read data.
- out_data  out  WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  marks the final word of a window.
- busy  out  1  a window is in progress.
- trig_lost  out  16  saturating count of triggers dropped while busy.

## Operation
- States:
  - IDLE: on trigger, latch trig_addr = wr_addr and go to HDR (if enabled) or READ.
  - HDR: emit one header word, then go to READ.
  - READ: issue window reads.
  - DRAIN: all reads issued; wait until every word has been accepted, then return to IDLE.
- Read address: ain = trig_addr - PRETRIG + k, computed modulo 2**SIZE, where k = 0 … PRETRIG+POSTTRIG-1. Wrap-around below 0 and above 2**SIZE-1 is natural truncation.
- Post-trigger gating: read k is issued only when k < PRETRIG + ((wr_addr - trig_addr) mod 2**SIZE). This means an address is never read before it has been written.
- Backpressure uses a credit scheme. A read is issued only if the skid FIFO holds fewer than 4 entries including reads in flight. No word is ever dropped.
- trigger while busy: ignored, and trig_lost increments, saturating at 16'hFFFF.
- Reset mid-window: the window is abandoned and all state is cleared.

## Timing
- Reset values:
  - ain = 0, rd_en = 0, out_data = 0, out_valid = 0, out_last = 0, busy = 0, trig_lost = 0.
  - State is IDLE and the skid FIFO is empty.
- Buffer read contract: ain is presented in cycle t and rd_en is asserted in cycle t+1 for that read. dout is valid at posedge t+2. Fixed 2-cycle read latency, one read per cycle maximum.
- Trigger to first ain: 1 cycle. First ain to first out_valid: 3 cycles (2 cycles latency plus the FIFO register).
- Throughput: with out_ready held high, one word per cycle.
- Stream handshake: a transfer occurs on out_valid & out_ready. out_valid and out_data stay stable while not accepted.
- out_last is asserted with word PRETRIG+POSTTRIG-1 only.
- busy rises the cycle after the trigger and falls the cycle after the out_last transfer. A trigger arriving in that same falling cycle is accepted.

## Configuration
- RINGBUFFER_READOUT_HEADER_EN defined:
  - Each window is preceded by one header word: {2'b10, trig_addr} zero-extended or truncated to WIDTH.
  - out_last is still asserted only on the final sample.
- Not defined: no HDR state; the first stream word is sample k=0.

## Structure
- Shared package mmaps_digitizer_pkg holds:
  - the SIZE/WIDTH defaults;
  - the readout state enum (IDLE, HDR, READ, DRAIN);
  - the header tag constant 2'b10;
  - the read latency constant RB_RD_LAT = 2.
- Sub-module readout_skid_fifo: 4-entry, WIDTH+1 bits wide (data plus last), with occupancy output. It is used for the credit check.

## Test plan
- wr_addr = 1000 free-running, trigger with PRETRIG=4 and POSTTRIG=4 → ain sequence 996…1003; out_data equals the model buffer contents; out_last on the 8th word.
- wr_addr = 2 at trigger, PRETRIG=4 → ain sequence 4094, 4095, 0, 1, …; the wrap is correct.
- wr_addr frozen at the trigger address, then advanced one step every 10 cycles → post-trigger reads never reach ain ≥ wr_addr.
- out_ready toggled on a random 30% duty cycle → all words are delivered in order with no duplicates, and out_data is stable while stalled.
- Second trigger during a window, then a third one cycle after out_last → trig_lost = 1 and the third window runs.
- rst_n asserted during READ → outputs return to reset values asynchronously; the next trigger after release produces a complete window.
